conf_int_mac_dot_sched: RTL and testbench

CONF_INT_MAC_DOT_SCHED -- requirements
Module: conf_int_mac_dot_sched

---
 rtl/conf_int_mac_dot_sched_pkg.sv | 22 ++
 rtl/conf_int_mac_acc_dp.sv | 65 ++++++
 rtl/conf_int_mac_dot_sched.sv | 101 ++++++++++
 tb/tb_conf_int_mac_dot_sched.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/conf_int_mac_dot_sched_pkg.sv
// ---------------------------------------------------------------
// conf_int_mac_dot_sched_pkg : shared FSM states and default widths
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

package conf_int_mac_dot_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } sched_state_t;

   localparam int DEF_DATA_PATH_BITWIDTH = 16;
   localparam int DEF_OP_BITWIDTH        = 16;
   localparam int DEF_LEN_WIDTH          = 8;

endpackage

`default_nettype wire

// File: rtl/conf_int_mac_acc_dp.sv
// ---------------------------------------------------------------
// conf_int_mac_acc_dp : operand registers, unsigned MAC, sticky overflow
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module conf_int_mac_acc_dp
   import conf_int_mac_dot_sched_pkg::*;
#(
   parameter int DATA_PATH_BITWIDTH = DEF_DATA_PATH_BITWIDTH,
   parameter int OP_BITWIDTH        = DEF_OP_BITWIDTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          acc_clr,
   input  logic                          op_en,
   input  logic [DATA_PATH_BITWIDTH-1:0] a,
   input  logic [DATA_PATH_BITWIDTH-1:0] b,
   output logic [DATA_PATH_BITWIDTH-1:0] acc,
   output logic                          ovf
);

   // Product is kept at least 2*DW wide so the overflow test sees every bit.
   localparam int PROD_W = DATA_PATH_BITWIDTH +
                           ((OP_BITWIDTH > DATA_PATH_BITWIDTH) ? OP_BITWIDTH : DATA_PATH_BITWIDTH);

   logic [DATA_PATH_BITWIDTH-1:0] a_reg;
   logic [DATA_PATH_BITWIDTH-1:0] b_reg;
   logic                          mac_pend;
   logic [PROD_W-1:0]             prod;
   logic [DATA_PATH_BITWIDTH:0]   sum;
   logic                          prod_ovf;

   always_comb begin
      prod     = PROD_W'(a_reg) * PROD_W'(b_reg);
      prod_ovf = |prod[PROD_W-1:DATA_PATH_BITWIDTH];
      sum      = {1'b0, acc} + {1'b0, prod[DATA_PATH_BITWIDTH-1:0]};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_reg    <= '0;
         b_reg    <= '0;
         mac_pend <= 1'b0;
         acc      <= '0;
         ovf      <= 1'b0;
      end else begin
         if (op_en) begin
            a_reg <= a;
            b_reg <= b;
         end
         mac_pend <= op_en & ~acc_clr;
         if (acc_clr) begin
            acc <= '0;
            ovf <= 1'b0;
         end else if (mac_pend) begin
            acc <= sum[DATA_PATH_BITWIDTH-1:0];
            ovf <= ovf | prod_ovf | sum[DATA_PATH_BITWIDTH];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/conf_int_mac_dot_sched.sv
// ---------------------------------------------------------------
// conf_int_mac_dot_sched : dot-product job scheduler (FSM, pair counter, handshakes)
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module conf_int_mac_dot_sched
   import conf_int_mac_dot_sched_pkg::*;
#(
   parameter int DATA_PATH_BITWIDTH = DEF_DATA_PATH_BITWIDTH,
   parameter int OP_BITWIDTH        = DEF_OP_BITWIDTH,
   parameter int LEN_WIDTH          = DEF_LEN_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [LEN_WIDTH-1:0]          len,
   output logic                          busy,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_PATH_BITWIDTH-1:0] a,
   input  logic [DATA_PATH_BITWIDTH-1:0] b,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [DATA_PATH_BITWIDTH-1:0] res,
   output logic                          ovf
);

   sched_state_t         state_q, state_d;
   logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
   logic                 acc_clr;
   logic                 op_en;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_clr = 1'b0;
      op_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               acc_clr = 1'b1;
               if (len != '0) begin
                  cnt_d   = len;
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            if (in_valid) begin
               op_en = 1'b1;
               cnt_d = cnt_q - LEN_WIDTH'(1);
               if (cnt_q == LEN_WIDTH'(1)) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: state_d = ST_DONE;
         ST_DONE: begin
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // All handshake outputs are pure decodes of the state register.
   assign busy      = (state_q != ST_IDLE);
   assign in_ready  = (state_q == ST_RUN);
   assign res_valid = (state_q == ST_DONE);

   conf_int_mac_acc_dp #(
      .DATA_PATH_BITWIDTH (DATA_PATH_BITWIDTH),
      .OP_BITWIDTH        (OP_BITWIDTH)
   ) u_dp (
      .clk     (clk),
      .rst     (rst),
      .acc_clr (acc_clr),
      .op_en   (op_en),
      .a       (a),
      .b       (b),
      .acc     (res),
      .ovf     (ovf)
   );

endmodule

`default_nettype wire

// File: tb/tb_conf_int_mac_dot_sched.sv
// ---------------------------------------------------------------
// tb_conf_int_mac_dot_sched : directed stimulus with result scoreboard
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_conf_int_mac_dot_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  len = '0;
   logic        busy;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [15:0] res;
   logic        ovf;

   int tests = 0;
   int fails = 0;
   logic [16:0] sb_q[$];   // {ovf, res}

   always #5 clk = ~clk;

   conf_int_mac_dot_sched dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .busy      (busy),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res       (res),
      .ovf       (ovf)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [7:0] l);
      start = 1'b1;
      len   = l;
      tick();
      start = 1'b0;
   endtask

   task automatic send_pair(input logic [15:0] av, input logic [15:0] bv);
      int n = 0;
      a = av;
      b = bv;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready) check("in_ready_timeout", 0, 1);
      tick();
   endtask

   task automatic wait_done();
      int n = 0;
      while (!res_valid && n < 50) begin
         tick();
         n++;
      end
      if (!res_valid) check("res_valid_timeout", 0, 1);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   // Monitor: every result handshake is compared against the scoreboard head.
   always @(negedge clk) begin
      if (rst && res_valid && res_ready) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_result", 1, 0);
         end else begin
            logic [16:0] e;
            e = sb_q.pop_front();
            check("sb_res", 32'(res), 32'(e[15:0]));
            check("sb_ovf", 32'(ovf), 32'(e[16]));
         end
      end
   end

   initial begin
      logic [15:0] held;
      #2;
      check("rst_busy", 32'(busy), 0);
      check("rst_in_ready", 32'(in_ready), 0);
      check("rst_res_valid", 32'(res_valid), 0);
      check("rst_res", 32'(res), 0);
      check("rst_ovf", 32'(ovf), 0);
      tick();
      rst = 1'b1;
      tick();

      // Basic job: 6 + 20 + 7 = 33, result two cycles after the last accept
      sb_q.push_back({1'b0, 16'd33});
      do_start(8'd3);
      send_pair(16'd2, 16'd3);
      send_pair(16'd4, 16'd5);
      send_pair(16'd1, 16'd7);
      in_valid = 1'b0;
      check("lat_drain_valid", 32'(res_valid), 0);
      check("lat_drain_busy", 32'(busy), 1);
      tick();
      check("lat_done_valid", 32'(res_valid), 1);
      wait_done();

      // Stalls and backpressure: 100 + 400 = 500
      sb_q.push_back({1'b0, 16'd500});
      do_start(8'd2);
      send_pair(16'd10, 16'd10);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      check("stall_in_ready", 32'(in_ready), 1);
      check("stall_no_result", 32'(res_valid), 0);
      send_pair(16'd20, 16'd20);
      in_valid = 1'b0;
      tick();
      check("bp_valid", 32'(res_valid), 1);
      held = res;
      check("bp_res", 32'(held), 500);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("bp_stable_res", 32'(res), 32'(held));
         check("bp_stable_valid", 32'(res_valid), 1);
      end
      wait_done();
      check("bp_idle_busy", 32'(busy), 0);
      check("bp_idle_valid", 32'(res_valid), 0);

      // Zero-length job
      sb_q.push_back({1'b0, 16'd0});
      do_start(8'd0);
      check("zero_valid", 32'(res_valid), 1);
      check("zero_res", 32'(res), 0);
      wait_done();

      // Start during RUN is ignored: 1 + 4 + 9 = 14
      sb_q.push_back({1'b0, 16'd14});
      do_start(8'd3);
      send_pair(16'd1, 16'd1);
      in_valid = 1'b0;
      do_start(8'd5);
      send_pair(16'd2, 16'd2);
      send_pair(16'd3, 16'd3);
      in_valid = 1'b0;
      wait_done();

      // Product overflow then wrap: 65536 -> 0, +5
      sb_q.push_back({1'b1, 16'd5});
      do_start(8'd2);
      send_pair(16'd256, 16'd256);
      send_pair(16'd1, 16'd5);
      in_valid = 1'b0;
      wait_done();
      sb_q.push_back({1'b0, 16'd9});
      do_start(8'd1);
      send_pair(16'd3, 16'd3);
      in_valid = 1'b0;
      wait_done();

      // Accumulation carry-out: 65535 + 1 wraps to 0
      sb_q.push_back({1'b1, 16'd0});
      do_start(8'd2);
      send_pair(16'd65535, 16'd1);
      send_pair(16'd1, 16'd1);
      in_valid = 1'b0;
      wait_done();

      // Mid-job reset
      do_start(8'd4);
      send_pair(16'd3, 16'd4);
      send_pair(16'd5, 16'd6);
      in_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check("mrst_busy", 32'(busy), 0);
      check("mrst_in_ready", 32'(in_ready), 0);
      check("mrst_res_valid", 32'(res_valid), 0);
      check("mrst_res", 32'(res), 0);
      check("mrst_ovf", 32'(ovf), 0);
      tick();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("post_rst_busy", 32'(busy), 0);
         check("post_rst_valid", 32'(res_valid), 0);
      end
      sb_q.push_back({1'b0, 16'd42});
      do_start(8'd1);
      send_pair(16'd6, 16'd7);
      in_valid = 1'b0;
      wait_done();

      // Back-to-back jobs: start the cycle after the handshake
      sb_q.push_back({1'b0, 16'd81});
      do_start(8'd1);
      send_pair(16'd9, 16'd9);
      in_valid = 1'b0;
      wait_done();
      sb_q.push_back({1'b0, 16'd16});
      do_start(8'd1);
      check("b2b_busy", 32'(busy), 1);
      send_pair(16'd2, 16'd8);
      in_valid = 1'b0;
      wait_done();

      tick();
      check("sb_empty", 32'(sb_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
